// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, product and state encodings, price lookup
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_10   = 2'b01;
  localparam logic [1:0] COIN_20   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [3:0] PROD_SNACK  = 4'b1000;
  localparam logic [3:0] PROD_COFFEE = 4'b0100;
  localparam logic [3:0] PROD_DRINK  = 4'b0010;
  localparam logic [3:0] PROD_CANDY  = 4'b0001;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CREDIT = 3'd1;
  localparam logic [2:0] ST_VEND   = 3'd2;
  localparam logic [2:0] ST_PAYOUT = 3'd3;

  // Snack and candy are the cheap products; drink and coffee the dear ones.
  function automatic logic [2:0] price_of(input logic [3:0] prod,
                                          input logic [2:0] lo,
                                          input logic [2:0] hi);
    return ((prod & (PROD_SNACK | PROD_CANDY)) != 4'b0000) ? lo : hi;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable down-counter with zero flag
module vend_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; decrement holds at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - coin credit, product vend handshake and coin payout controller
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_MAX  = 5,
  parameter int PRICE_LO    = 3,
  parameter int PRICE_HI    = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int PAY_GAP     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic [3:0] choice,
  input  logic       choice_vld,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       pay_ack,
  output logic [3:0] vend_req,
  output logic       pay_req,
  output logic [2:0] credit,
  output logic [2:0] state,
  output logic       coin_reject,
  output logic       choice_deny,
  output logic       fault
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  // Timer counts down to zero on the last allowed cycle, hence the minus one.
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(PAY_GAP - 1);

  logic [3:0]    coin_sum;
  logic          coin_ok;
  logic          coin_bad;
  logic [2:0]    choice_price;
  logic [2:0]    vend_price;
  logic          choice_ok;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_dec;
  logic          tmr_zero;

  // coin code equals its value in 10-units for the two legal codes
  assign coin_sum     = {1'b0, credit} + {2'b00, coin};
  assign coin_ok      = (coin == COIN_10 || coin == COIN_20)
                     && (state == ST_IDLE || state == ST_CREDIT)
                     && !cancel && !choice_vld
                     && (coin_sum <= 4'(CREDIT_MAX));
  assign coin_bad     = (coin != COIN_NONE) && !coin_ok;
  assign choice_price = price_of(choice, 3'(PRICE_LO), 3'(PRICE_HI));
  assign vend_price   = price_of(vend_req, 3'(PRICE_LO), 3'(PRICE_HI));
  assign choice_ok    = $onehot(choice) && (credit >= choice_price);

  // One timer serves the ack timeout in VEND and the inter-coin gap in PAYOUT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = ACK_LOAD;
    tmr_dec  = 1'b0;
    case (state)
      ST_CREDIT: tmr_load = !cancel && choice_vld && choice_ok;
      ST_VEND:   tmr_dec  = !vend_ack;
      ST_PAYOUT: begin
        if (pay_req && pay_ack) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else begin
          tmr_dec = !pay_req;
        end
      end
      default: ;
    endcase
  end

  vend_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Transaction FSM: cancel beats choice beats coin within a cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      credit      <= 3'd0;
      vend_req    <= 4'd0;
      pay_req     <= 1'b0;
      coin_reject <= 1'b0;
      choice_deny <= 1'b0;
      fault       <= 1'b0;
    end else begin
      coin_reject <= coin_bad;
      choice_deny <= choice_vld && !(state == ST_CREDIT && (cancel || choice_ok));
      fault       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_ok) begin
            credit <= coin_sum[2:0];
            state  <= ST_CREDIT;
          end
        end
        ST_CREDIT: begin
          if (cancel) begin
            state   <= ST_PAYOUT;
            pay_req <= 1'b1;
          end else if (choice_vld) begin
            if (choice_ok) begin
              credit   <= credit - choice_price;
              vend_req <= choice;
              state    <= ST_VEND;
            end
          end else if (coin_ok) begin
            credit <= coin_sum[2:0];
          end
        end
        ST_VEND: begin
          if (vend_ack) begin
            vend_req <= 4'd0;
            if (credit != 3'd0) begin
              state   <= ST_PAYOUT;
              pay_req <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tmr_zero) begin
            fault    <= 1'b1;
            vend_req <= 4'd0;
            credit   <= credit + vend_price;
            state    <= ST_PAYOUT;
            pay_req  <= 1'b1;
          end
        end
        ST_PAYOUT: begin
          if (pay_req && pay_ack) begin
            pay_req <= 1'b0;
            credit  <= credit - 3'd1;
            if (credit == 3'd1)
              state <= ST_IDLE;
          end else if (!pay_req && tmr_zero) begin
            pay_req <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
